instruction_prefetch: RTL and testbench
=======================================

INSTRUCTION_PREFETCH -- requirements
Module: instruction_prefetch

Interface
REQ-001 SHALL have parameter WIDTH, default 16: instruction, PC and address width in bits.
REQ-002 SHALL have parameter DEPTH, default 4: prefetch queue entries, power of two, 2..16.
REQ-003 SHALL have parameter RESET_PC, default 16'h0000: fetch PC after reset.
REQ-004 SHALL have port clk, input, 1: sole clock, all state updates on rising edge.
REQ-005 SHALL have port reset_n, input, 1: reset, synchronous, active-low.
REQ-006 SHALL have port redirect, input, 1: branch/jump taken; flush and refetch from redirect_pc.
REQ-007 SHALL have port redirect_pc, input, WIDTH: new fetch PC, sampled when redirect=1.
REQ-008 SHALL have port imem_read, output, 1: memory read request.
REQ-009 SHALL have port imem_address, output, WIDTH: read address.
REQ-010 SHALL have port imem_rdata, input, WIDTH: read data, valid when imem_resp=1.
REQ-011 SHALL have port imem_resp, input, 1: read complete; meaningful only while imem_read=1.
REQ-012 SHALL have port deq_ready, input, 1: decode accepts the head entry this cycle.
REQ-013 SHALL have port out_valid, output, 1: queue non-empty.
REQ-014 SHALL have port out_instr, output, WIDTH: head instruction word.
REQ-015 SHALL have port out_pc, output, WIDTH: address the head instruction was fetched from.

Function
REQ-016 SHALL hold fetch PC register pc, request-address register req_addr, a DEPTH-entry FIFO of {pc, instr}, and count (0..DEPTH).
REQ-017 SHALL implement FSM states IDLE, FETCH, SQUASH; imem_read=1 in FETCH and SQUASH only; imem_address=req_addr.
REQ-018 SHALL keep imem_read and imem_address stable from assertion until the cycle imem_resp=1.
REQ-019 IDLE, redirect=0, count<DEPTH: SHALL load req_addr<=pc and enter FETCH.
REQ-020 FETCH, imem_resp=1, redirect=0: SHALL push {req_addr, imem_rdata}, set pc<=req_addr+2 modulo 2^WIDTH, and stay in FETCH with req_addr<=req_addr+2 if post-update count<DEPTH, else enter IDLE.
REQ-021 FETCH, imem_resp=0, redirect=1: SHALL enter SQUASH, keep req_addr, flush FIFO, set pc<=redirect_pc.
REQ-022 FETCH, imem_resp=1, redirect=1: SHALL discard imem_rdata, flush FIFO, set pc<=redirect_pc, enter IDLE.
REQ-023 SQUASH: SHALL discard any response, enter IDLE on imem_resp=1; redirect in SQUASH updates pc, FIFO stays empty.
REQ-024 IDLE, redirect=1: SHALL flush FIFO, set pc<=redirect_pc, remain IDLE.
REQ-025 SHALL pop head when out_valid=1 and deq_ready=1; out_instr/out_pc are combinational from head entry.
REQ-026 Simultaneous push and pop SHALL leave count unchanged; the FIFO never overflows because requests issue only when a slot is free for the response.
REQ-027 Redirect SHALL take priority over pop and push in the same cycle; the popped entry is still considered consumed by decode.
REQ-028 FIFO pointers SHALL wrap modulo DEPTH; PC arithmetic SHALL wrap modulo 2^WIDTH (16'hFFFE+2=16'h0000).
REQ-029 Peak throughput SHALL be one instruction per imem_resp cycle with single-cycle memory and deq_ready=1.

Reset
REQ-030 reset_n=0 at a clock edge SHALL set pc=RESET_PC, req_addr=RESET_PC, count=0, FIFO pointers=0, state=IDLE, overriding all inputs.
REQ-031 During and after reset, until the next transition: imem_read=0, out_valid=0.
REQ-032 Reset mid-read SHALL abandon the read; a response in the first post-reset cycle with imem_read=0 SHALL be ignored.

Verification
REQ-033 Reset, single-cycle memory, deq_ready=1: imem_address 0x0000,0x0002,0x0004,...; out_pc follows one cycle after each response; out_instr matches memory.
REQ-034 deq_ready=0, DEPTH=4: exactly 4 responses accepted, then imem_read=0, out_valid=1, out_pc=0x0000; raise deq_ready -> fetch resumes at 0x0008.
REQ-035 Memory latency 3, redirect to 0x1000 in 2nd wait cycle of read at 0x0004 -> SQUASH, address held 0x0004, response discarded, next request 0x1000, no 0x0004 entry output.
REQ-036 Redirect to 0x0200 same cycle as imem_resp with queue holding 2 entries -> out_valid=0 next cycle, data dropped, next request 0x0200.
REQ-037 Redirect to 0xFFFC -> entries 0xFFFC, 0xFFFE, 0x0000 delivered in order.
REQ-038 Reset asserted during FETCH with imem_resp high next cycle -> no push, pc=RESET_PC, out_valid=0.

Source files
------------

// File: rtl/instruction_prefetch.sv
// instruction_prefetch
//   Fetches sequential 16-bit-aligned instruction words from instruction memory
//   into a small FIFO for the decoder. A new read is issued only while the FIFO
//   has room for its response, so the FIFO can never overflow. A redirect
//   flushes the FIFO and restarts fetching at redirect_pc; a read that is still
//   outstanding when the redirect arrives is finished in SQUASH, and its data is
//   dropped.
//
// Ports
//   clk, reset_n               clock, synchronous active-low reset
//   redirect, redirect_pc      flush and refetch request
//   imem_read, imem_address    memory read request (held until imem_resp)
//   imem_rdata, imem_resp      memory read data / completion
//   deq_ready                  decoder takes the head entry
//   out_valid, out_instr,
//   out_pc                     head entry of the prefetch queue
//
// state  | meaning
// IDLE   | no read outstanding; waits for a free slot
// FETCH  | read outstanding at req_addr; response is pushed
// SQUASH | read outstanding but flushed by a redirect; response discarded
module instruction_prefetch #(
  parameter int                 WIDTH    = 16,
  parameter int                 DEPTH    = 4,
  parameter logic [WIDTH-1:0]   RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             imem_read,
  output logic [WIDTH-1:0] imem_address,
  input  logic [WIDTH-1:0] imem_rdata,
  input  logic             imem_resp,
  input  logic             deq_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_instr,
  output logic [WIDTH-1:0] out_pc
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [WIDTH-1:0] STEP = WIDTH'(2);

  typedef enum logic [1:0] {IDLE, FETCH, SQUASH} state_t;

  state_t           state;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] req_addr;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_next;

  logic [WIDTH-1:0] fifo_pc    [DEPTH];
  logic [WIDTH-1:0] fifo_instr [DEPTH];

  logic push;
  logic pop;

  assign imem_read    = (state != IDLE);
  assign imem_address = req_addr;
  assign out_valid    = (count != '0);
  assign out_instr    = fifo_instr[rd_ptr];
  assign out_pc       = fifo_pc[rd_ptr];

  assign pop  = out_valid && deq_ready;
  assign push = reset_n && (state == FETCH) && imem_resp && !redirect;

  // Occupancy after this cycle's push/pop, used to decide whether the next
  // sequential read still has a slot for its response.
  always_comb begin
    count_next = count;
    if (push && !pop)
      count_next = count + 1'b1;
    else if (!push && pop)
      count_next = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      req_addr <= RESET_PC;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else if (redirect) begin
      // Redirect wins over push and pop; a head popped this cycle is simply
      // flushed along with everything else.
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      pc     <= redirect_pc;
      case (state)
        FETCH:   state <= imem_resp ? IDLE : SQUASH;
        SQUASH:  if (imem_resp) state <= IDLE;
        default: state <= IDLE;
      endcase
    end else begin
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      count <= count_next;
      case (state)
        IDLE: begin
          if (count < DEPTH_C) begin
            req_addr <= pc;
            state    <= FETCH;
          end
        end
        FETCH: begin
          if (imem_resp) begin
            pc <= req_addr + STEP;
            if (count_next < DEPTH_C)
              req_addr <= req_addr + STEP;
            else
              state <= IDLE;
          end
        end
        SQUASH: begin
          if (imem_resp) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Queue storage needs no reset: only entries below count are ever visible.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr]    <= req_addr;
      fifo_instr[wr_ptr] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_instruction_prefetch.sv
module tb_instruction_prefetch;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        imem_read;
  logic [15:0] imem_address;
  logic [15:0] imem_rdata;
  logic        imem_resp;
  logic        deq_ready;
  logic        out_valid;
  logic [15:0] out_instr;
  logic [15:0] out_pc;

  always #5 clk = ~clk;

  instruction_prefetch #(.WIDTH(16), .DEPTH(4), .RESET_PC(16'h0000)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .imem_read    (imem_read),
    .imem_address (imem_address),
    .imem_rdata   (imem_rdata),
    .imem_resp    (imem_resp),
    .deq_ready    (deq_ready),
    .out_valid    (out_valid),
    .out_instr    (out_instr),
    .out_pc       (out_pc)
  );

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] instr;
  } ent_t;

  int total = 0;
  int bad   = 0;

  logic [15:0] exp_addr_q[$];
  ent_t        exp_out_q[$];

  // Memory model: responds after lat cycles of a held request.
  int lat        = 1;
  bit mem_en     = 1'b0;
  bit force_resp = 1'b0;
  int wcnt       = 0;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  always_comb begin
    imem_resp  = force_resp || (mem_en && imem_read && (wcnt >= lat - 1));
    imem_rdata = mem_word(imem_address);
  end

  always @(posedge clk) begin
    if (!imem_read || imem_resp) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic ent_t mk(input logic [15:0] a);
    ent_t e;
    e.pc    = a;
    e.instr = mem_word(a);
    return e;
  endfunction

  // Scoreboard: every accepted response and every dequeued entry is compared
  // against the expectations queued by the directed steps.
  always @(negedge clk) begin
    if (reset_n) begin
      if (imem_read && imem_resp) begin
        if (exp_addr_q.size() == 0) begin
          total++;
          bad++;
          $error("FAIL resp_addr observed=%h expected=none", imem_address);
        end else begin
          chk("resp_addr", imem_address, exp_addr_q.pop_front());
        end
      end
      if (out_valid && deq_ready) begin
        if (exp_out_q.size() == 0) begin
          total++;
          bad++;
          $error("FAIL deq observed=%h expected=none", out_pc);
        end else begin
          ent_t e;
          e = exp_out_q.pop_front();
          chk("deq_pc", out_pc, e.pc);
          chk("deq_instr", out_instr, e.instr);
        end
      end
    end
  end

  task automatic apply_reset();
    @(posedge clk); #1;
    reset_n    = 1'b0;
    redirect   = 1'b0;
    mem_en     = 1'b0;
    force_resp = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_imem_read", 16'(imem_read), 16'h0);
    chk("rst_out_valid", 16'(out_valid), 16'h0);
  endtask

  task automatic drain(input string tag);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(posedge clk); #1;
      if (exp_addr_q.size() == 0) begin
        mem_en = 1'b0;
        done   = 1'b1;
      end
    end
    chk({tag, "_addr_left"}, 16'(exp_addr_q.size()), 16'h0);
    for (int i = 0; i < 50 && exp_out_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    chk({tag, "_out_left"}, 16'(exp_out_q.size()), 16'h0);
    exp_addr_q.delete();
    exp_out_q.delete();
  endtask

  initial begin
    bit found;
    reset_n     = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 16'h0;
    deq_ready   = 1'b0;

    // Sequential stream, single-cycle memory, decoder always ready.
    apply_reset();
    lat = 1; deq_ready = 1'b1; mem_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp_addr_q.push_back(16'(2 * i));
      exp_out_q.push_back(mk(16'(2 * i)));
    end
    reset_n = 1'b1;
    chk("post_rst_imem_read", 16'(imem_read), 16'h0);
    chk("post_rst_out_valid", 16'(out_valid), 16'h0);
    drain("seq");

    // Decoder stalled: queue fills to DEPTH, fetching stops, then resumes at 8.
    apply_reset();
    lat = 1; deq_ready = 1'b0; mem_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      exp_addr_q.push_back(16'(2 * i));
      exp_out_q.push_back(mk(16'(2 * i)));
    end
    reset_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("full_imem_read", 16'(imem_read), 16'h0);
    chk("full_out_valid", 16'(out_valid), 16'h1);
    chk("full_out_pc", out_pc, 16'h0000);
    chk("full_resp_count", 16'(exp_addr_q.size()), 16'h2);
    deq_ready = 1'b1;
    drain("full");

    // Latency 3, redirect during the second wait cycle of the read at 0x0004.
    apply_reset();
    lat = 3; deq_ready = 1'b1; mem_en = 1'b1;
    exp_addr_q.push_back(16'h0000);
    exp_addr_q.push_back(16'h0002);
    exp_addr_q.push_back(16'h0004);
    exp_addr_q.push_back(16'h1000);
    exp_addr_q.push_back(16'h1002);
    exp_out_q.push_back(mk(16'h0000));
    exp_out_q.push_back(mk(16'h0002));
    exp_out_q.push_back(mk(16'h1000));
    exp_out_q.push_back(mk(16'h1002));
    reset_n = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(posedge clk); #1;
      if (imem_read && imem_address == 16'h0004 && wcnt == 1) found = 1'b1;
    end
    chk("squash_reached", 16'(found), 16'h1);
    redirect = 1'b1; redirect_pc = 16'h1000;
    @(posedge clk); #1;
    redirect = 1'b0;
    chk("squash_imem_read", 16'(imem_read), 16'h1);
    chk("squash_hold_addr", imem_address, 16'h0004);
    chk("squash_out_valid", 16'(out_valid), 16'h0);
    drain("squash");

    // Redirect coinciding with a response while two entries are queued.
    apply_reset();
    lat = 1; deq_ready = 1'b0; mem_en = 1'b1;
    exp_addr_q.push_back(16'h0000);
    exp_addr_q.push_back(16'h0002);
    exp_addr_q.push_back(16'h0004);
    exp_addr_q.push_back(16'h0200);
    exp_addr_q.push_back(16'h0202);
    exp_out_q.push_back(mk(16'h0200));
    exp_out_q.push_back(mk(16'h0202));
    reset_n = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clk); #1;
      if (imem_read && imem_address == 16'h0004) found = 1'b1;
    end
    chk("redir_resp_reached", 16'(found), 16'h1);
    chk("redir_two_queued", 16'(out_valid), 16'h1);
    redirect = 1'b1; redirect_pc = 16'h0200;
    @(posedge clk); #1;
    redirect = 1'b0;
    chk("redir_flushed", 16'(out_valid), 16'h0);
    deq_ready = 1'b1;
    drain("redir");

    // Redirect near the top of the address space: PC wraps to 0x0000.
    apply_reset();
    lat = 1; deq_ready = 1'b1; mem_en = 1'b1;
    exp_addr_q.push_back(16'hFFFC);
    exp_addr_q.push_back(16'hFFFE);
    exp_addr_q.push_back(16'h0000);
    exp_addr_q.push_back(16'h0002);
    exp_out_q.push_back(mk(16'hFFFC));
    exp_out_q.push_back(mk(16'hFFFE));
    exp_out_q.push_back(mk(16'h0000));
    exp_out_q.push_back(mk(16'h0002));
    reset_n = 1'b1; redirect = 1'b1; redirect_pc = 16'hFFFC;
    @(posedge clk); #1;
    redirect = 1'b0;
    drain("wrap");

    // Reset during an outstanding read, stray response right after reset.
    apply_reset();
    lat = 1; deq_ready = 1'b1; mem_en = 1'b0;
    reset_n = 1'b1; redirect = 1'b1; redirect_pc = 16'h0300;
    @(posedge clk); #1;
    redirect = 1'b0;
    @(posedge clk); #1;
    chk("midrd_imem_read", 16'(imem_read), 16'h1);
    chk("midrd_addr", imem_address, 16'h0300);
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1; force_resp = 1'b1;
    chk("midrd_rst_read", 16'(imem_read), 16'h0);
    chk("midrd_rst_valid", 16'(out_valid), 16'h0);
    @(posedge clk); #1;
    force_resp = 1'b0;
    chk("midrd_no_push", 16'(out_valid), 16'h0);
    chk("midrd_refetch_read", 16'(imem_read), 16'h1);
    chk("midrd_refetch_addr", imem_address, 16'h0000);
    repeat (2) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
